// File: rtl/video_pkg.sv
// Shared types and timing constant sets for the video timing generator.
package video_pkg;

  typedef enum logic [1:0] {
    PAT_GRAD  = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pat_mode_e;

  // 640x480@60
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // 1280x720@60
  localparam int HD_H_ACTIVE = 1280;
  localparam int HD_H_FP     = 110;
  localparam int HD_H_SYNC   = 40;
  localparam int HD_H_BP     = 220;
  localparam int HD_V_ACTIVE = 720;
  localparam int HD_V_FP     = 5;
  localparam int HD_V_SYNC   = 5;
  localparam int HD_V_BP     = 20;

  function automatic logic [2:0] bar_next(input logic [2:0] idx);
    return (idx == 3'd7) ? idx : idx + 3'd1;
  endfunction

endpackage

// File: rtl/video_timing_gen_pattern_gen.sv
// Stage-2 pixel colour generation from stage-1 coordinates, active flag and
// bar index, using the mode/colour latched at the start of the frame.
module pattern_gen
  import video_pkg::*;
#(
  parameter int CW       = 8,
  parameter int XW       = 10,
  parameter int YW       = 10,
  parameter int CHK_LOG2 = 5
) (
  input  logic            pixclk,
  input  logic            rst_n,
  input  logic [XW-1:0]   i_x,
  input  logic [YW-1:0]   i_y,
  input  logic            i_active,
  input  logic [2:0]      i_bar_idx,
  input  logic [1:0]      i_mode,
  input  logic [3*CW-1:0] i_solid,
  output logic [CW-1:0]   o_red,
  output logic [CW-1:0]   o_green,
  output logic [CW-1:0]   o_blue
);

  logic [CW-1:0] w_r, w_g, w_b;
  logic          w_chk;

  always_comb begin
    w_r   = '0;
    w_g   = '0;
    w_b   = '0;
    w_chk = i_x[CHK_LOG2] ^ i_y[CHK_LOG2];
    if (i_active) begin
      case (pat_mode_e'(i_mode))
        PAT_GRAD: begin
          w_r = CW'(i_x >> 2);
          w_b = CW'(i_y >> 2);
        end
        PAT_BARS: begin
          w_r = {CW{~i_bar_idx[1]}};
          w_g = {CW{~i_bar_idx[2]}};
          w_b = {CW{~i_bar_idx[0]}};
        end
        PAT_CHECK: begin
          w_r = {CW{w_chk}};
          w_g = {CW{w_chk}};
          w_b = {CW{w_chk}};
        end
        PAT_SOLID: {w_r, w_g, w_b} = i_solid;
        default: ;
      endcase
    end
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      o_red   <= '0;
      o_green <= '0;
      o_blue  <= '0;
    end else begin
      o_red   <= w_r;
      o_green <= w_g;
      o_blue  <= w_b;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Video timing and test-pattern generator: raster counters, sync decode,
// frame-boundary mode latch and frame counter, with a two-stage output pipe.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CW       = 8,
  parameter int XW       = 10,
  parameter int YW       = 10,
  parameter int CHK_LOG2 = 5
) (
  input  logic            pixclk,
  input  logic            rst_n,
  input  logic [1:0]      mode,
  input  logic [3*CW-1:0] solid_rgb,
  output logic            de,
  output logic            hsync,
  output logic            vsync,
  output logic [CW-1:0]   red,
  output logic [CW-1:0]   green,
  output logic [CW-1:0]   blue,
  output logic [XW-1:0]   x,
  output logic [YW-1:0]   y,
  output logic            frame_start,
  output logic [15:0]     frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BW      = H_ACTIVE / 8;

  if (H_TOTAL > (1 << XW)) begin : g_h_overflow
    $error("video_timing_gen: H_TOTAL does not fit in XW bits");
  end
  if (V_TOTAL > (1 << YW)) begin : g_v_overflow
    $error("video_timing_gen: V_TOTAL does not fit in YW bits");
  end

  // One spare bit so compares against H_TOTAL-sized bounds never truncate.
  localparam logic [XW:0] H_ACT_C  = (XW+1)'(H_ACTIVE);
  localparam logic [XW:0] HS_ON_C  = (XW+1)'(H_ACTIVE + H_FP);
  localparam logic [XW:0] HS_OFF_C = (XW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [XW:0] H_LAST_C = (XW+1)'(H_TOTAL - 1);
  localparam logic [XW:0] BW_LST_C = (XW+1)'(BW - 1);
  localparam logic [YW:0] V_ACT_C  = (YW+1)'(V_ACTIVE);
  localparam logic [YW:0] VS_ON_C  = (YW+1)'(V_ACTIVE + V_FP);
  localparam logic [YW:0] VS_OFF_C = (YW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [YW:0] V_LAST_C = (YW+1)'(V_TOTAL - 1);

  logic [XW-1:0]   r_hc;
  logic [YW-1:0]   r_vc;
  pat_mode_e       r_mode;
  logic [3*CW-1:0] r_solid;
  logic            r_first_done;

  logic [XW-1:0]   r1_x;
  logic [YW-1:0]   r1_y;
  logic            r1_active, r1_hs, r1_vs, r1_fs;
  logic [XW-1:0]   r1_bar_pos;
  logic [2:0]      r1_bar_idx;

  logic            r_de, r_hsync, r_vsync, r_frame_start;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [15:0]     r_frame_cnt;

  logic w_h_last, w_v_last, w_origin, w_active, w_hs_on, w_vs_on;

  assign w_h_last = ({1'b0, r_hc} == H_LAST_C);
  assign w_v_last = ({1'b0, r_vc} == V_LAST_C);
  assign w_origin = (r_hc == '0) && (r_vc == '0);
  assign w_active = ({1'b0, r_hc} < H_ACT_C) && ({1'b0, r_vc} < V_ACT_C);
  assign w_hs_on  = ({1'b0, r_hc} >= HS_ON_C) && ({1'b0, r_hc} < HS_OFF_C);
  assign w_vs_on  = ({1'b0, r_vc} >= VS_ON_C) && ({1'b0, r_vc} < VS_OFF_C);

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (w_h_last) begin
      r_hc <= '0;
      r_vc <= w_v_last ? '0 : r_vc + YW'(1);
    end else begin
      r_hc <= r_hc + XW'(1);
    end
  end

  // Mode/colour only change at the frame origin so a frame is never mixed.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode       <= PAT_GRAD;
      r_solid      <= '0;
      r_first_done <= 1'b0;
    end else if (w_origin) begin
      r_mode       <= pat_mode_e'(mode);
      r_solid      <= solid_rgb;
      r_first_done <= 1'b1;
    end
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      r1_x       <= '0;
      r1_y       <= '0;
      r1_active  <= 1'b0;
      r1_hs      <= ~H_POL;
      r1_vs      <= ~V_POL;
      r1_fs      <= 1'b0;
      r1_bar_pos <= '0;
      r1_bar_idx <= '0;
    end else begin
      r1_x      <= r_hc;
      r1_y      <= r_vc;
      r1_active <= w_active;
      r1_hs     <= w_hs_on ? H_POL : ~H_POL;
      r1_vs     <= w_vs_on ? V_POL : ~V_POL;
      r1_fs     <= w_origin && r_first_done;
      if (r_hc == '0) begin
        r1_bar_pos <= '0;
        r1_bar_idx <= '0;
      end else if ({1'b0, r1_bar_pos} == BW_LST_C) begin
        r1_bar_pos <= '0;
        r1_bar_idx <= bar_next(r1_bar_idx);
      end else begin
        r1_bar_pos <= r1_bar_pos + XW'(1);
      end
    end
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      r_de          <= 1'b0;
      r_hsync       <= ~H_POL;
      r_vsync       <= ~V_POL;
      r_x           <= '0;
      r_y           <= '0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_de          <= r1_active;
      r_hsync       <= r1_hs;
      r_vsync       <= r1_vs;
      r_x           <= r1_x;
      r_y           <= r1_y;
      r_frame_start <= r1_fs;
      r_frame_cnt   <= r_frame_cnt + {15'd0, r1_fs};
    end
  end

  pattern_gen #(
    .CW       (CW),
    .XW       (XW),
    .YW       (YW),
    .CHK_LOG2 (CHK_LOG2)
  ) u_pattern_gen (
    .pixclk    (pixclk),
    .rst_n     (rst_n),
    .i_x       (r1_x),
    .i_y       (r1_y),
    .i_active  (r1_active),
    .i_bar_idx (r1_bar_idx),
    .i_mode    (r_mode),
    .i_solid   (r_solid),
    .o_red     (red),
    .o_green   (green),
    .o_blue    (blue)
  );

  assign de          = r_de;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign x           = r_x;
  assign y           = r_y;
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised video timing and test-pattern generator for the HDMI/DVI output path, one step up from the fixed 640x480 gradient source. It runs on the pixel clock and produces `de`, `hsync`, `vsync` and RGB pixel data, all pipeline-aligned. That bundle feeds the three per-channel TMDS encoders. Resolution, porches, sync polarity, colour depth and pattern are configurable; the pattern is selectable at run time and switches cleanly on frame boundaries.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal front porch / sync width / back porch
- `V_ACTIVE`, 480, visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical front porch / sync width / back porch
- `H_POL` / `V_POL`, 0 / 0, sync active level (1 = active-high)
- `CW`, 8, bits per colour channel
- `XW` / `YW`, 10 / 10, counter widths; elaboration error if H_TOTAL > 2^XW or V_TOTAL > 2^YW
- `CHK_LOG2`, 5, checkerboard square size is 2^CHK_LOG2 pixels

Ports:
- `pixclk`, in, 1, pixel clock
- `rst_n`, in, 1, asynchronous active-low reset
- `mode`, in, 2, pattern select; 0 gradient, 1 colour bars, 2 checkerboard, 3 solid
- `solid_rgb`, in, 3*CW, solid colour {R,G,B}
- `de`, out, 1, data enable (active area)
- `hsync` / `vsync`, out, 1, sync at the configured polarity
- `red` / `green` / `blue`, out, CW each, pixel data; 0 outside the active area
- `x` / `y`, out, XW / YW, coordinates of the pixel currently on the outputs
- `frame_start`, out, 1, one-cycle pulse aligned with pixel (0,0)
- `frame_cnt`, out, 16, completed-frame counter, wraps at 0xFFFF -> 0

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- `hc` counts 0..H_TOTAL-1 and wraps to 0. `vc` increments when `hc` wraps, and itself wraps after V_TOTAL-1.
- Active area: `hc` < H_ACTIVE and `vc` < V_ACTIVE.
- `hsync` is active for `hc` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), default 656..751.
- `vsync` is active for `vc` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), default 490..491.
- Mode latch: `mode` and `solid_rgb` are captured only when `hc`=0 and `vc`=0. A change mid-frame takes effect at the next frame, never mid-line.
- Mode 0, gradient: R = (x>>2) truncated to CW bits; G = 0; B = (y>>2) truncated to CW bits.
- Mode 1, colour bars:
  - Bar width BW = H_ACTIVE/8, computed at elaboration.
  - A bar-position counter and a 3-bit index `i` reset at `hc`=0. `i` increments each BW pixels and saturates at 7.
  - R = all-ones if ~i[1], G = all-ones if ~i[2], B = all-ones if ~i[0].
  - Resulting sequence: white, yellow, cyan, green, magenta, red, blue, black.
- Mode 2, checkerboard: white if x[CHK_LOG2] ^ y[CHK_LOG2], else black.
- Mode 3, solid: the latched `solid_rgb`.
- Outside the active area, RGB is 0 in every mode.
- `frame_cnt` increments in the same cycle that `frame_start` is asserted. It does not increment for the first frame after reset.

## Timing
- Two-stage pipeline:
  - Stage 1 registers the counters, sync levels, active flag and bar index.
  - Stage 2 registers RGB and copies everything else.
- All outputs are mutually aligned: the pixel at counter state (hc,vc) appears on the outputs 2 `pixclk` edges later.
- Reset values while `rst_n`=0: counters 0; `de`=0; `hsync`=~H_POL; `vsync`=~V_POL; RGB=0; `x`=`y`=0; `frame_start`=0; `frame_cnt`=0; latched mode=0; latched colour=0.
- Reset is asynchronous and may be asserted mid-frame. Outputs return to reset values immediately.
- After deassertion, pixel (0,0) appears after the 2nd rising edge. `frame_start` is not pulsed for that first frame; it first pulses at the start of the second frame.
- Simultaneous wrap (`hc`=H_TOTAL-1 and `vc`=V_TOTAL-1): both counters go to 0 on the same edge.

## Structure
- Shared package `video_pkg` holds:
  - the `mode` enum (PAT_GRAD, PAT_BARS, PAT_CHECK, PAT_SOLID);
  - default 640x480@60 timing constants;
  - a 1280x720 constant set.
- One sub-module, `pattern_gen`: stage 2 RGB generation from coordinates, active flag, bar index and latched mode/colour. Counters, sync decode, mode latch and frame counter stay in the top module.

## Test plan
- Defaults, 2 full frames: `de` high for exactly 640x480 = 307200 cycles per frame; `hsync` low for 96 cycles starting 656 cycles after `de` rises; `vsync` low on lines 490-491; frame period 420000 cycles.
- Mode 1, line 0: R/G/B = FF/FF/FF at x 0..79, FF/FF/00 at x 80..159, and so on, with 00/00/00 at x 560..639.
- Mode switched 0->2 at line 200: gradient continues to end of frame; checkerboard starts at the next pixel (0,0). At (32,0) the output is FF/FF/FF and at (32,32) it is 00/00/00.
- H_POL=V_POL=1 with 1280x720 constants (`XW`=11): `hsync` is high for 40 cycles per line, H_TOTAL=1650, V_TOTAL=750.
- `rst_n` pulsed low at line 300: outputs immediately take reset values; after release, pixel (0,0) appears at edge 2; `frame_cnt` reads 0.
- Mode 3 with `solid_rgb`=0x123456: every active pixel is 12/34/56 and blanking is 0. Check `frame_cnt` wrap from 0xFFFF to 0 by forcing the counter.
